// File: rtl/datapath_sequencer.sv
// Sequencer that feeds the register-file/ALU datapath: 16 register-init writes,
// then program words one per cycle until a halt word or the end of the buffer.
module datapath_sequencer #(
  parameter logic [3:0]  INIT_OPCODE = 4'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pgm_we,
  input  logic        init_we,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        start,
  input  logic        skip_init,
  input  logic        run_en,
  input  logic        abort,
  output logic [15:0] Instruction,
  output logic        InitSel,
  output logic [15:0] DataInit,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pc,
  output logic [4:0]  issue_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  pc_q, pc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic        init_sel_q, init_sel_d;
  logic [15:0] data_init_q, data_init_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] pgm_buf  [16];
  logic [15:0] init_buf [16];

  logic        buf_wr_ok;
  logic        run_step;
  logic [3:0]  run_pc;
  logic [4:0]  run_cnt;
  logic [15:0] run_word;

  // Buffers are only writable while idle; reset and abort both block writes.
  assign buf_wr_ok = !reset && !abort && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (buf_wr_ok && pgm_we) begin
      pgm_buf[wr_addr] <= wr_data;
    end
    if (buf_wr_ok && init_we) begin
      init_buf[wr_addr] <= wr_data;
    end
  end

  // Outputs are computed for the cycle that follows the edge, so the state
  // presented in a cycle and its instruction always come from the same flop set.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    instr_d     = NOP_INSTR;
    init_sel_d  = 1'b1;
    data_init_d = 16'h0000;
    run_step    = 1'b0;
    run_pc      = pc_q;
    run_cnt     = cnt_q;
    run_word    = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = 4'd0;
          cnt_d   = 5'd0;
          run_pc  = 4'd0;
          run_cnt = 5'd0;
          if (skip_init) begin
            run_step = 1'b1;
          end else begin
            state_d     = ST_INIT;
            k_d         = 4'd0;
            instr_d     = {INIT_OPCODE, 4'd0, 8'h00};
            init_sel_d  = 1'b0;
            data_init_d = init_buf[4'd0];
          end
        end
      end
      ST_INIT: begin
        if (k_q == 4'd15) begin
          run_step = 1'b1;
        end else begin
          k_d         = k_q + 4'd1;
          instr_d     = {INIT_OPCODE, k_d, 8'h00};
          init_sel_d  = 1'b0;
          data_init_d = init_buf[k_d];
        end
      end
      ST_RUN: begin
        // issue_count of 16 means index 15 went out last cycle: implicit halt.
        if (cnt_q == 5'd16) begin
          state_d = ST_DONE;
        end else begin
          run_step = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (run_step) begin
      state_d  = ST_RUN;
      run_word = pgm_buf[run_pc];
      if (!run_en) begin
        pc_d  = run_pc;
        cnt_d = run_cnt;
      end else if (run_word[15:12] == HALT_OPCODE) begin
        state_d = ST_DONE;
      end else begin
        instr_d = run_word;
        pc_d    = run_pc + 4'd1;
        cnt_d   = run_cnt + 5'd1;
      end
    end

    if (abort) begin
      state_d     = ST_IDLE;
      k_d         = k_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      instr_d     = NOP_INSTR;
      init_sel_d  = 1'b1;
      data_init_d = 16'h0000;
    end

    busy_d = (state_d == ST_INIT) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= 4'd0;
      pc_q        <= 4'd0;
      cnt_q       <= 5'd0;
      instr_q     <= NOP_INSTR;
      init_sel_q  <= 1'b1;
      data_init_q <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      init_sel_q  <= init_sel_d;
      data_init_q <= data_init_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Instruction = instr_q;
  assign InitSel     = init_sel_q;
  assign DataInit    = data_init_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pc          = pc_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: reset, init+halt, implicit halt,
// stall, ignored inputs while busy, and abort followed by a restart.
module tb_datapath_sequencer;

  logic        clk;
  logic        reset;
  logic        pgm_we;
  logic        init_we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        skip_init;
  logic        run_en;
  logic        abort;
  logic [15:0] Instruction;
  logic        InitSel;
  logic [15:0] DataInit;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [4:0]  issue_count;

  int tests;
  int fails;

  localparam logic [15:0] NOP = 16'hF000;

  datapath_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pgm_we      (pgm_we),
    .init_we     (init_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .skip_init   (skip_init),
    .run_en      (run_en),
    .abort       (abort),
    .Instruction (Instruction),
    .InitSel     (InitSel),
    .DataInit    (DataInit),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ins, input logic isel,
                         input logic [15:0] dinit, input logic bsy, input logic dn);
    check({tag, " Instruction"}, 32'(Instruction), 32'(ins));
    check({tag, " InitSel"},     32'(InitSel),     32'(isel));
    check({tag, " DataInit"},    32'(DataInit),    32'(dinit));
    check({tag, " busy"},        32'(busy),        32'(bsy));
    check({tag, " done"},        32'(done),        32'(dn));
  endtask

  task automatic chk_pc(input string tag, input logic [3:0] p, input logic [4:0] c);
    check({tag, " pc"},          32'(pc),          32'(p));
    check({tag, " issue_count"}, 32'(issue_count), 32'(c));
  endtask

  function automatic logic [15:0] pword(input int i);
    return 16'h2000 + 16'(i) * 16'h0011;
  endfunction

  task automatic chk_init_word(input string tag, input int k);
    chk_out($sformatf("%s k=%0d", tag, k), {4'h0, 4'(k), 8'h00}, 1'b0, 16'h1000 + 16'(k), 1'b1, 1'b0);
  endtask

  logic [15:0] halt_pgm [4];

  initial begin
    tests = 0;
    fails = 0;
    halt_pgm[0] = 16'h0123;
    halt_pgm[1] = 16'h1456;
    halt_pgm[2] = 16'h2789;
    halt_pgm[3] = 16'hF000;

    // Reset for two cycles with random inputs and start held high.
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      pgm_we    = 1'($urandom);
      init_we   = 1'($urandom);
      wr_addr   = 4'($urandom);
      wr_data   = 16'($urandom);
      skip_init = 1'($urandom);
      run_en    = 1'($urandom);
      abort     = 1'($urandom);
      start     = 1'b1;
      tick();
    end
    chk_out("reset", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_pc("reset", 4'd0, 5'd0);
    $display("[TB] reset: Instruction=%h busy=%b pc=%0d", Instruction, busy, pc);

    reset = 1'b0; start = 1'b0; pgm_we = 1'b0; init_we = 1'b0;
    abort = 1'b0; skip_init = 1'b0; run_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0;
    tick();
    chk_out("post-reset idle", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Load init buffer and a short program ending in a halt word.
    for (int k = 0; k < 16; k++) begin
      init_we = 1'b1; wr_addr = 4'(k); wr_data = 16'h1000 + 16'(k);
      tick();
    end
    init_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pgm_we = 1'b1; wr_addr = 4'(i); wr_data = halt_pgm[i];
      tick();
    end
    pgm_we = 1'b0;

    // Init plus explicit halt.
    start = 1'b1; skip_init = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_init_word("init+halt", k);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("init+halt word%0d", i), halt_pgm[i], 1'b1, 16'h0000, 1'b1, 1'b0);
      chk_pc($sformatf("init+halt word%0d", i), 4'(i + 1), 5'(i + 1));
      tick();
    end
    chk_out("init+halt done", NOP, 1'b1, 16'h0000, 1'b0, 1'b1);
    chk_pc("init+halt done", 4'd3, 5'd3);
    $display("[TB] init+halt: done=%b issue_count=%0d pc=%0d", done, issue_count, pc);
    tick();
    chk_out("init+halt idle", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_pc("init+halt idle", 4'd3, 5'd3);

    // Implicit halt: full buffer without halt words, skip_init.
    for (int i = 0; i < 16; i++) begin
      pgm_we = 1'b1; wr_addr = 4'(i); wr_data = pword(i);
      tick();
    end
    pgm_we = 1'b0;
    start = 1'b1; skip_init = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("implicit word%0d", i), pword(i), 1'b1, 16'h0000, 1'b1, 1'b0);
      chk_pc($sformatf("implicit word%0d", i), 4'(i + 1), 5'(i + 1));
      tick();
    end
    chk_out("implicit done", NOP, 1'b1, 16'h0000, 1'b0, 1'b1);
    chk_pc("implicit done", 4'd0, 5'd16);
    $display("[TB] implicit halt: done=%b issue_count=%0d", done, issue_count);
    tick();
    chk_out("implicit idle", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Stall for two cycles after index 4.
    start = 1'b1; skip_init = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("stall word%0d", i), pword(i), 1'b1, 16'h0000, 1'b1, 1'b0);
      if (i == 4) run_en = 1'b0;
      tick();
    end
    chk_out("stall nop1", NOP, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk_pc("stall nop1", 4'd5, 5'd5);
    tick();
    chk_out("stall nop2", NOP, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk_pc("stall nop2", 4'd5, 5'd5);
    run_en = 1'b1;
    tick();
    for (int i = 5; i < 16; i++) begin
      chk_out($sformatf("stall word%0d", i), pword(i), 1'b1, 16'h0000, 1'b1, 1'b0);
      chk_pc($sformatf("stall word%0d", i), 4'(i + 1), 5'(i + 1));
      tick();
    end
    chk_out("stall done", NOP, 1'b1, 16'h0000, 1'b0, 1'b1);
    $display("[TB] stall: run completed, issue_count=%0d", issue_count);
    tick();

    // Ignored inputs: buffer write and second start while running.
    start = 1'b1; skip_init = 1'b1;
    tick();
    start = 1'b0;
    chk_out("ignore word0", pword(0), 1'b1, 16'h0000, 1'b1, 1'b0);
    pgm_we = 1'b1; wr_addr = 4'd2; wr_data = 16'hF000; start = 1'b1; skip_init = 1'b0;
    tick();
    pgm_we = 1'b0; start = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk_out($sformatf("ignore word%0d", i), pword(i), 1'b1, 16'h0000, 1'b1, 1'b0);
      tick();
    end
    chk_out("ignore done", NOP, 1'b1, 16'h0000, 1'b0, 1'b1);
    chk_pc("ignore done", 4'd0, 5'd16);
    $display("[TB] ignored inputs: issue_count=%0d", issue_count);
    tick();

    // Abort in INIT at k=5, then restart from k=0 and run to completion.
    start = 1'b1; skip_init = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_init_word("abort", k);
      if (k == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    chk_out("abort idle", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_pc("abort idle", 4'd0, 5'd0);
    $display("[TB] abort: busy=%b done=%b Instruction=%h", busy, done, Instruction);
    tick();
    chk_out("abort idle2", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_init_word("restart", k);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("restart word%0d", i), pword(i), 1'b1, 16'h0000, 1'b1, 1'b0);
      tick();
    end
    chk_out("restart done", NOP, 1'b1, 16'h0000, 1'b0, 1'b1);
    chk_pc("restart done", 4'd0, 5'd16);
    $display("[TB] restart: issue_count=%0d", issue_count);
    tick();
    chk_out("final idle", NOP, 1'b1, 16'h0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Sequencer for the single-cycle register-file/ALU datapath. Holds a 16-word program buffer and a 16-word register-init buffer, both loaded while idle. On a start pulse it drives the datapath's `Instruction`, `InitSel` and `DataInit` inputs: first 16 register-init writes, then program words, one per cycle, until a halt word or the end of the buffer.

## Interface
- `INIT_OPCODE`, default 4'h0: opcode placed in `[15:12]` for init writes. The datapath Control block must decode it with WriteEn=1.
- `HALT_OPCODE`, default 4'hF: opcode that ends a run. It is never issued to the datapath.
- `NOP_INSTR`, default 16'hF000: idle word. The datapath Control block must decode its opcode with WriteEn=0.
- `clk  in  1`  clock; all state updates on the rising edge.
- `reset  in  1`  synchronous, active-high.
- `pgm_we  in  1`  program buffer write strobe; honoured only in IDLE.
- `init_we  in  1`  init buffer write strobe; honoured only in IDLE.
- `wr_addr  in  4`  buffer write address, shared by both buffers.
- `wr_data  in  16`  buffer write data.
- `start  in  1`  single-cycle start request; honoured only in IDLE.
- `skip_init  in  1`  sampled with `start`; 1 = go straight to RUN.
- `run_en  in  1`  0 in RUN = stall: NOP issued, pc held.
- `abort  in  1`  return to IDLE from any state.
- `Instruction  out  16`  registered instruction to the datapath.
- `InitSel  out  1`  registered; 0 selects `DataInit` as write data, 1 selects ALU result.
- `DataInit  out  16`  registered init write data.
- `busy  out  1`  high in INIT and RUN.
- `done  out  1`  one-cycle pulse on normal completion.
- `pc  out  4`  index of the next program word.
- `issue_count  out  5`  program words issued in the current or last run, 0..16.

## Operation
- States: IDLE, INIT, RUN, DONE.
- Buffers are 16x16 and not reset. If `pgm_we` and `init_we` are both high, both buffers are written.
- **IDLE:**
  - Outputs `Instruction`=NOP_INSTR, `InitSel`=1.
  - On `start` with `skip_init`=0: go to INIT, clear init index k, pc and issue_count.
  - On `start` with `skip_init`=1: go to RUN, clear pc and issue_count.
- **INIT (k = 0..15):**
  - `Instruction`={INIT_OPCODE, k[3:0], 8'h00}, `InitSel`=0, `DataInit`=init_buf[k].
  - After the cycle with k=15, go to RUN.
- **RUN:**
  - If `run_en`=0: NOP_INSTR, `InitSel`=1, pc and issue_count held.
  - Else if pgm_buf[pc][15:12]==HALT_OPCODE: NOP_INSTR, go to DONE.
  - Else: `Instruction`=pgm_buf[pc], `InitSel`=1, pc+1, issue_count+1.
  - After issuing index 15, go to DONE (implicit halt). pc wraps to 0 and is never used past 15.
- **DONE:** `done`=1 and NOP_INSTR for one cycle, then IDLE. pc and issue_count hold until the next start.
- **abort:** beats every other input. Next cycle is IDLE with NOP_INSTR, `InitSel`=1, busy=0, and no done pulse. pc and issue_count freeze at their current values.
- `start`, `pgm_we` and `init_we` outside IDLE are ignored, with no side effects.
- `DataInit` outside INIT is 16'h0000.

## Timing
- Reset values: `Instruction`=NOP_INSTR, `InitSel`=1, `DataInit`=0, `busy`=0, `done`=0, `pc`=0, `issue_count`=0, state IDLE.
- Reset has priority over `abort`, `start` and writes.
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge T: the first INIT word (or the first RUN word if `skip_init`) is valid in cycle T+1.
- A register written by the datapath in cycle N can be read by the instruction in cycle N+1; the sequencer inserts no bubbles.
- A buffer write at edge T is visible to a `start` sampled at edge T+1.
- Full run with init and no halt: 16 INIT + 16 RUN + 1 DONE = 33 busy/done cycles from start to IDLE.
- `busy` is high in INIT and RUN only; it is low in the DONE cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs -> all outputs at reset values; `start` during reset is ignored.
- **Init plus halt:**
  - Stimulus: init_buf[k]=16'h1000+k, pgm_buf[0..2]=16'h0123, 16'h1456, 16'h2789, pgm_buf[3]=16'hF000, then `start`.
  - Required: 16 cycles of {4'h0,k,8'h00} with `DataInit`=16'h1000+k and `InitSel`=0; then the 3 program words with `InitSel`=1; then `done` for 1 cycle; issue_count=3, pc=3.
- **Implicit halt:** no halt word in the buffer, `skip_init`=1 -> 16 words issued in consecutive cycles; `done` in the cycle after index 15; issue_count=16.
- **Stall:** `run_en`=0 for 2 cycles after index 4 is issued -> 2 NOP_INSTR cycles; pc stays at 5; issue_count stays at 5; index 5 is issued when `run_en` returns to 1.
- **Abort:** `abort` in the INIT cycle with k=5 -> next cycle IDLE, NOP_INSTR, busy=0, no done pulse; a following `start` restarts from k=0.
- **Ignored inputs:** `pgm_we` to address 2 and a second `start` while busy -> buffer unchanged (verified by a later run) and the current run is unaffected.
